// File: rtl/oci_dct_trace_monitor.sv
// rtl/oci_dct_trace_monitor.sv - OCI debug-capture trace monitor with circular buffer; optional macro OCI_TRACE_TIMESTAMP_EN
module oci_dct_trace_monitor #(
  parameter int DATA_W    = 30,
  parameter int COUNT_W   = 4,
  parameter int ADDR_W    = 4,
  parameter int WRAP_MODE = 0,
  parameter int DROP_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         dct_buffer,
  input  logic [COUNT_W-1:0]        dct_count,
  input  logic                      test_ending,
  input  logic                      test_has_ended,
  input  logic                      rd_req,
  output logic                      rd_valid,
  output logic [COUNT_W+DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]           level,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_count,
  output logic                      capturing,
`ifdef OCI_TRACE_TIMESTAMP_EN
  output logic                      done,
  output logic [15:0]               rd_ts
`else
  output logic                      done
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int REC_W = COUNT_W + DATA_W;
`ifdef OCI_TRACE_TIMESTAMP_EN
  localparam int ENT_W = REC_W + 16;
`else
  localparam int ENT_W = REC_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ENT_W-1:0]    rd_data_q, rd_data_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];

  logic                full_now;
  logic                empty_now;
  logic                cap_evt;
  logic                rd_acc;
  logic                wr_en;
  logic                overwrite;
  logic                drop;
  logic [ENT_W-1:0]    wr_entry;

`ifdef OCI_TRACE_TIMESTAMP_EN
  logic [15:0]         ts_q, ts_d;

  // Free-running cycle stamp stored alongside every entry
  always_comb begin
    ts_d = ts_q + 16'd1;
  end

  // Timestamp register
  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end

  assign wr_entry = {ts_q, dct_count, dct_buffer};
  assign rd_ts    = rd_data_q[ENT_W-1:REC_W];
`else
  assign wr_entry = {dct_count, dct_buffer};
`endif

  // Capture / read decode; full and empty reflect the state before this cycle's update
  always_comb begin
    full_now  = (level_q == DEPTH_LVL);
    empty_now = (level_q == '0);
    cap_evt   = (state_q == ST_CAPTURE) && (dct_count != cnt_q) && (dct_count != '0);
    rd_acc    = rd_req && !empty_now;
    wr_en     = 1'b0;
    overwrite = 1'b0;
    drop      = 1'b0;
    if (cap_evt) begin
      if (!full_now) begin
        wr_en = 1'b1;
      end else if (WRAP_MODE != 0) begin
        // Full in wrap mode: always write; without a read the oldest entry is discarded
        wr_en     = 1'b1;
        overwrite = !rd_acc;
        drop      = !rd_acc;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Next-state for the end-of-test FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CAPTURE: begin
        if (test_has_ended)   state_d = ST_DONE;
        else if (test_ending) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (test_has_ended) state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
  end

  // Buffer pointers, occupancy, drop accounting and registered read port
  always_comb begin
    cnt_d      = dct_count;
    wr_ptr_d   = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = (rd_acc || overwrite) ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    if (wr_en && !rd_acc && !overwrite) level_d = level_q + (ADDR_W+1)'(1);
    else if (!wr_en && rd_acc)          level_d = level_q - (ADDR_W+1)'(1);
    overflow_d = overflow_q || drop;
    drop_d     = (drop && (drop_q != DROP_MAX)) ? drop_q + DROP_W'(1) : drop_q;
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CAPTURE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Entry storage; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q[REC_W-1:0];
  assign level      = level_q;
  assign empty      = (level_q == '0);
  assign full       = (level_q == DEPTH_LVL);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign capturing  = (state_q == ST_CAPTURE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_oci_dct_trace_monitor.sv
// tb/tb_oci_dct_trace_monitor.sv - scoreboard bench for oci_dct_trace_monitor in stop and wrap modes
module tb_oci_dct_trace_monitor;

  localparam int ENT = 34;
  localparam int NBUF = 4096;
  typedef enum int {M_CAP = 0, M_DRAIN = 1, M_DONE = 2} mst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        test_ending = 1'b0;
  logic        test_has_ended = 1'b0;
  logic        rd_req = 1'b0;

  logic           rd_valid0, rd_valid1, empty0, empty1, full0, full1;
  logic           ovf0, ovf1, cap0, cap1, done0, done1;
  logic [ENT-1:0] rd_data0, rd_data1;
  logic [2:0]     level0, level1;
  logic [3:0]     drop0;
  logic [2:0]     drop1;

  oci_dct_trace_monitor #(.DATA_W(30), .COUNT_W(4), .ADDR_W(2), .WRAP_MODE(0), .DROP_W(4)) u_stop (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_req(rd_req),
    .rd_valid(rd_valid0), .rd_data(rd_data0), .level(level0), .empty(empty0), .full(full0),
    .overflow(ovf0), .drop_count(drop0), .capturing(cap0), .done(done0));

  oci_dct_trace_monitor #(.DATA_W(30), .COUNT_W(4), .ADDR_W(2), .WRAP_MODE(1), .DROP_W(3)) u_wrap (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_req(rd_req),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .level(level1), .empty(empty1), .full(full1),
    .overflow(ovf1), .drop_count(drop1), .capturing(cap1), .done(done1));

  // Reference model: per instance, a log of accepted entries (head..tail) and a queue of expected reads
  logic [ENT-1:0] hist [2][NBUF];
  int             head [2];
  int             tail [2];
  logic [ENT-1:0] expq [2][NBUF];
  int             eh [2];
  int             et [2];
  logic [ENT-1:0] held [2];
  bit             ovf_m [2];
  int             drops [2];
  mst_t           st = M_CAP;
  logic [3:0]     prev = '0;

  int total = 0;
  int bad = 0;

  int  sz;
  bit  cap_m, rd_m, was_full, wrap_m;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        head[i] = 0; tail[i] = 0; eh[i] = 0; et[i] = 0;
        held[i] = '0; ovf_m[i] = 1'b0; drops[i] = 0;
      end else begin
        wrap_m   = (i == 1);
        sz       = tail[i] - head[i];
        cap_m    = (st == M_CAP) && (dct_count != prev) && (dct_count != 0);
        rd_m     = rd_req && (sz > 0);
        was_full = (sz == 4);
        if (rd_m) begin
          expq[i][et[i]] = hist[i][head[i]];
          et[i]++;
          head[i]++;
        end
        if (cap_m) begin
          if (!was_full || (wrap_m && rd_m)) begin
            hist[i][tail[i]] = {dct_count, dct_buffer};
            tail[i]++;
          end else begin
            if (wrap_m) begin
              head[i]++;
              hist[i][tail[i]] = {dct_count, dct_buffer};
              tail[i]++;
            end
            ovf_m[i] = 1'b1;
            drops[i] = (drops[i] + 1 > (i == 0 ? 15 : 7)) ? (i == 0 ? 15 : 7) : drops[i] + 1;
          end
        end
      end
    end
    if (reset) begin
      st = M_CAP;
      prev = '0;
    end else begin
      if (st != M_DONE && test_has_ended) st = M_DONE;
      else if (st == M_CAP && test_ending) st = M_DRAIN;
      prev = dct_count;
    end
  end

  task automatic check(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  logic           a_rv;
  logic [ENT-1:0] a_rd;

  // Monitor: pops expected reads when due and compares status against the model every cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      a_rv = (i == 0) ? rd_valid0 : rd_valid1;
      a_rd = (i == 0) ? rd_data0 : rd_data1;
      if (eh[i] < et[i]) begin
        check("rd_valid", i, 64'(a_rv), 64'd1);
        check("rd_data", i, 64'(a_rd), 64'(expq[i][eh[i]]));
        held[i] = expq[i][eh[i]];
        eh[i]++;
      end else begin
        check("rd_valid_idle", i, 64'(a_rv), 64'd0);
        check("rd_data_hold", i, 64'(a_rd), 64'(held[i]));
      end
      check("level", i, 64'((i == 0) ? level0 : level1), 64'(tail[i] - head[i]));
      check("empty", i, 64'((i == 0) ? empty0 : empty1), 64'(tail[i] == head[i]));
      check("full", i, 64'((i == 0) ? full0 : full1), 64'(tail[i] - head[i] == 4));
      check("overflow", i, 64'((i == 0) ? ovf0 : ovf1), 64'(ovf_m[i]));
      check("drop_count", i, (i == 0) ? 64'(drop0) : 64'(drop1), 64'(drops[i]));
      check("capturing", i, 64'((i == 0) ? cap0 : cap1), 64'(st == M_CAP));
      check("done", i, 64'((i == 0) ? done0 : done1), 64'(st == M_DONE));
    end
  end

  task automatic step(input logic [3:0] c, input logic [29:0] b, input logic r);
    dct_count = c; dct_buffer = b; rd_req = r;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; test_ending = 1'b0; test_has_ended = 1'b0; rd_req = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  int rd_pct, end_at, has_at;
  logic [3:0] c_r;

  initial begin
    do_reset(3);
    // basic capture then two reads
    step(4'd1, 30'h0AA, 0); step(4'd2, 30'h0BB, 0); step(4'd2, 30'h1, 0);
    step(4'd2, 30'h2, 1); step(4'd2, 30'h3, 1); step(4'd2, 30'h4, 1); step(4'd2, 30'h5, 0);
    // held count yields one entry, zero yields none
    for (int k = 0; k < 10; k++) step(4'd3, 30'(k), 0);
    step(4'd0, 30'h77, 0); step(4'd0, 30'h78, 1); step(4'd0, 30'h79, 0);
    // fill past depth, then capture while full with a simultaneous read, then drain
    do_reset(2);
    for (int k = 1; k <= 6; k++) step(4'(k), 30'(16'hC00 + k), 0);
    step(4'd7, 30'hC07, 1);
    for (int k = 0; k < 6; k++) step(4'd7, 30'h0, 1);
    // end protocol: DRAIN blocks captures, reads continue, then DONE
    for (int k = 1; k <= 3; k++) step(4'(k + 8), 30'(k), 0);
    test_ending = 1'b1;
    step(4'd12, 30'h12, 0); step(4'd13, 30'h13, 1); step(4'd14, 30'h14, 1);
    test_has_ended = 1'b1;
    step(4'd15, 30'h15, 1); step(4'd1, 30'h16, 0);
    test_ending = 1'b0; test_has_ended = 1'b0;
    step(4'd2, 30'h17, 1); step(4'd3, 30'h18, 0);
    // reset mid-drain
    do_reset(2);
    for (int k = 1; k <= 3; k++) step(4'(k), 30'(k), 0);
    test_ending = 1'b1;
    step(4'd5, 30'h5, 1); step(4'd6, 30'h6, 1);
    reset = 1'b1; step(4'd7, 30'h7, 1);
    reset = 1'b0; test_ending = 1'b0;
    step(4'd7, 30'h8, 0); step(4'd8, 30'h9, 1);
    // randomized phases
    for (int p = 0; p < 8; p++) begin
      do_reset(2);
      case (p % 4)
        0: rd_pct = 10;
        1: rd_pct = 35;
        2: rd_pct = 60;
        default: rd_pct = 95;
      endcase
      end_at = (p % 2 == 1) ? $urandom_range(50, 300) : 100000;
      has_at = end_at + $urandom_range(1, 80);
      for (int k = 0; k < 350; k++) begin
        test_ending = (k >= end_at);
        test_has_ended = (k >= has_at);
        reset = ($urandom_range(0, 199) == 0);
        c_r = ($urandom_range(0, 2) == 0) ? dct_count : 4'($urandom_range(0, 15));
        step(c_r, 30'($urandom), ($urandom_range(0, 99) < rd_pct));
      end
      reset = 1'b0;
    end
    do_reset(2);
    step(4'd0, 30'h0, 0); step(4'd0, 30'h0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
